// File: rtl/ssd1306_frame_streamer.sv
// SSD1306 128x64 sequencer: panel reset pulse, init command list, then windowed framebuffer
// streaming to an SPI master. One byte in flight at a time; each byte waits on spi_ready.
module ssd1306_frame_streamer #(
    parameter int RESET_CYCLES   = 1000,
    parameter int POWERUP_CYCLES = 1000,
    parameter int FB_ADDR_WIDTH  = 10
) (
    input  logic                     clk_in,
    input  logic                     reset_n_in,
    input  logic                     frame_req,
    output logic                     busy,
    output logic                     init_done,
    output logic                     frame_done,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    input  logic [7:0]               fb_data,
    output logic                     spi_transmitt,
    output logic [7:0]               spi_data,
    output logic                     spi_deactivate_cs,
    input  logic                     spi_ready,
    output logic                     oled_dc,
    output logic                     oled_res_n
);

    localparam int DLY_MAX = (RESET_CYCLES > POWERUP_CYCLES) ? RESET_CYCLES : POWERUP_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam logic [DLY_W-1:0]         RST_LAST  = DLY_W'(RESET_CYCLES - 1);
    localparam logic [DLY_W-1:0]         PWR_LAST  = DLY_W'(POWERUP_CYCLES - 1);
    localparam logic [4:0]               INIT_LAST = 5'd24;
    localparam logic [4:0]               WIN_LAST  = 5'd5;
    localparam logic [FB_ADDR_WIDTH-1:0] FB_LAST   = '1;

    typedef enum logic [2:0] {
        S_RST_LOW, S_PWR_WAIT, S_INIT, S_IDLE, S_WIN, S_FETCH, S_LOAD
    } state_t;

    // P_XMIT is the request cycle; P_SKIP covers the master's late drop of spi_ready.
    typedef enum logic [1:0] {P_ARM, P_XMIT, P_SKIP, P_WAIT} phase_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    phase_t                     r_phase;
    logic [DLY_W-1:0]           r_dly_cnt;
    logic [4:0]                 r_cmd_idx;
    logic [FB_ADDR_WIDTH-1:0]   r_byte_cnt;
    logic [7:0]                 r_spi_data;
    logic                       r_dcs;
    logic                       r_dc;
    logic                       r_init_done;
    logic                       r_frame_done;

    logic                       w_sending;
    logic                       w_launch;
    logic                       w_byte_done;
    logic                       w_last_byte;
    logic [7:0]                 w_tx_byte;

    function automatic logic [7:0] init_rom(input logic [4:0] idx);
        case (idx)
            5'd0:  return 8'hAE;
            5'd1:  return 8'hD5;
            5'd2:  return 8'h80;
            5'd3:  return 8'hA8;
            5'd4:  return 8'h3F;
            5'd5:  return 8'hD3;
            5'd6:  return 8'h00;
            5'd7:  return 8'h40;
            5'd8:  return 8'h8D;
            5'd9:  return 8'h14;
            5'd10: return 8'h20;
            5'd11: return 8'h00;
            5'd12: return 8'hA1;
            5'd13: return 8'hC8;
            5'd14: return 8'hDA;
            5'd15: return 8'h12;
            5'd16: return 8'h81;
            5'd17: return 8'hCF;
            5'd18: return 8'hD9;
            5'd19: return 8'hF1;
            5'd20: return 8'hDB;
            5'd21: return 8'h40;
            5'd22: return 8'hA4;
            5'd23: return 8'hA6;
            5'd24: return 8'hAF;
            default: return 8'h00;
        endcase
    endfunction

    // Full-screen window: columns 0..127, pages 0..7.
    function automatic logic [7:0] win_rom(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'h21;
            5'd1:    return 8'h00;
            5'd2:    return 8'h7F;
            5'd3:    return 8'h22;
            5'd4:    return 8'h00;
            5'd5:    return 8'h07;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        w_sending   = (r_state == S_INIT) || (r_state == S_WIN) || (r_state == S_LOAD);
        w_launch    = w_sending && (r_phase == P_ARM) && spi_ready;
        w_byte_done = w_sending && (r_phase == P_WAIT) && spi_ready;
        w_tx_byte   = 8'h00;
        w_last_byte = 1'b0;
        case (r_state)
            S_INIT: begin
                w_tx_byte   = init_rom(r_cmd_idx);
                w_last_byte = (r_cmd_idx == INIT_LAST);
            end
            S_WIN: begin
                w_tx_byte   = win_rom(r_cmd_idx);
                w_last_byte = (r_cmd_idx == WIN_LAST);
            end
            S_LOAD: begin
                w_tx_byte   = fb_data;
                w_last_byte = (r_byte_cnt == FB_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= S_RST_LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RST_LOW:  if (r_dly_cnt == RST_LAST) w_state_nxt = S_PWR_WAIT;
            S_PWR_WAIT: if (r_dly_cnt == PWR_LAST) w_state_nxt = S_INIT;
            S_INIT:     if (w_byte_done && w_last_byte) w_state_nxt = S_IDLE;
            S_IDLE:     if (frame_req) w_state_nxt = S_WIN;
            S_WIN:      if (w_byte_done && w_last_byte) w_state_nxt = S_FETCH;
            S_FETCH:    w_state_nxt = S_LOAD;
            S_LOAD:     if (w_byte_done) w_state_nxt = w_last_byte ? S_IDLE : S_FETCH;
            default:    w_state_nxt = S_RST_LOW;
        endcase
    end

    always_comb begin
        busy              = (r_state != S_IDLE);
        oled_res_n        = (r_state != S_RST_LOW);
        spi_transmitt     = (r_phase == P_XMIT);
        spi_data          = r_spi_data;
        spi_deactivate_cs = r_dcs;
        oled_dc           = r_dc;
        init_done         = r_init_done;
        frame_done        = r_frame_done;
        fb_addr           = r_byte_cnt;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_phase      <= P_ARM;
            r_dly_cnt    <= '0;
            r_cmd_idx    <= '0;
            r_byte_cnt   <= '0;
            r_spi_data   <= '0;
            r_dcs        <= 1'b0;
            r_dc         <= 1'b0;
            r_init_done  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;

            case (r_phase)
                P_ARM:   if (w_launch) r_phase <= P_XMIT;
                P_XMIT:  r_phase <= P_SKIP;
                P_SKIP:  r_phase <= P_WAIT;
                default: if (spi_ready) r_phase <= P_ARM;
            endcase

            // Byte and framing are captured together so they hold until the next request.
            if (w_launch) begin
                r_spi_data <= w_tx_byte;
                r_dcs      <= w_last_byte;
                r_dc       <= (r_state == S_LOAD);
            end

            if ((r_state == S_RST_LOW && r_dly_cnt == RST_LAST) ||
                (r_state == S_PWR_WAIT && r_dly_cnt == PWR_LAST)) begin
                r_dly_cnt <= '0;
            end else if (r_state == S_RST_LOW || r_state == S_PWR_WAIT) begin
                r_dly_cnt <= r_dly_cnt + DLY_W'(1);
            end else begin
                r_dly_cnt <= '0;
            end

            if (w_byte_done) begin
                if (r_state == S_LOAD) begin
                    r_byte_cnt <= r_byte_cnt + FB_ADDR_WIDTH'(1);
                    if (w_last_byte) r_frame_done <= 1'b1;
                end else begin
                    r_cmd_idx <= w_last_byte ? 5'd0 : r_cmd_idx + 5'd1;
                    if (r_state == S_INIT && w_last_byte) r_init_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_frame_streamer.sv
`timescale 1ns/1ps
module tb_ssd1306_frame_streamer;
    localparam int RST_CYC = 40;
    localparam int PWR_CYC = 30;
    localparam int FBW     = 10;
    localparam int NB      = 1024;

    logic           clk_in     = 1'b0;
    logic           reset_n_in = 1'b0;
    logic           frame_req  = 1'b0;
    logic           spi_ready  = 1'b1;
    logic [7:0]     fb_data    = 8'h00;
    logic           busy, init_done, frame_done, spi_transmitt, spi_deactivate_cs;
    logic           oled_dc, oled_res_n;
    logic [FBW-1:0] fb_addr;
    logic [7:0]     spi_data;

    always #5 clk_in = ~clk_in;

    ssd1306_frame_streamer #(
        .RESET_CYCLES(RST_CYC), .POWERUP_CYCLES(PWR_CYC), .FB_ADDR_WIDTH(FBW)
    ) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in), .frame_req(frame_req),
        .busy(busy), .init_done(init_done), .frame_done(frame_done),
        .fb_addr(fb_addr), .fb_data(fb_data),
        .spi_transmitt(spi_transmitt), .spi_data(spi_data),
        .spi_deactivate_cs(spi_deactivate_cs), .spi_ready(spi_ready),
        .oled_dc(oled_dc), .oled_res_n(oled_res_n)
    );

    // Synchronous-read framebuffer
    logic [7:0] mem [0:NB-1];
    always @(posedge clk_in) fb_data <= mem[fb_addr];

    typedef struct packed {
        logic [7:0] d;
        logic       dc;
        logic       dcs;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e_m;
    logic [7:0] init_tbl [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                  8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                  8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
    logic [7:0] win_tbl [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

    int total = 0, bad = 0;
    int spi_low = 8, cur_low = 0, lat = 0, stab_err = 0, data_tx = 0, fd_cnt = 0;
    logic [7:0] held = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // SPI master model + scoreboard monitor; ready is 1 cycle late to drop, then low spi_low cycles.
    always @(negedge clk_in) begin
        if (!reset_n_in) begin
            lat       = 0;
            spi_ready = 1'b1;
        end else begin
            if (frame_done) fd_cnt++;
            if (spi_transmitt) begin
                if (lat != 0) fail_now("single_request");
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_byte");
                end else begin
                    e_m = sb_q.pop_front();
                    chk("byte{data,dc,dcs}", {22'd0, spi_data, oled_dc, spi_deactivate_cs}, {22'd0, e_m});
                end
                if (oled_dc) data_tx++;
                held     = spi_data;
                cur_low  = spi_low;
                lat      = cur_low + 1;
                stab_err = 0;
            end else if (lat > 0) begin
                lat--;
                if (spi_data !== held) stab_err++;
                if (lat == 0) chk("spi_data_stable", stab_err, 0);
            end
            spi_ready = (lat == 0) || (lat == cur_low + 1);
        end
    end

    task automatic push_init();
        for (int i = 0; i < 25; i++) sb_q.push_back({init_tbl[i], 1'b0, i == 24});
    endtask

    task automatic push_frame(input int nbytes);
        for (int i = 0; i < 6; i++) sb_q.push_back({win_tbl[i], 1'b0, i == 5});
        for (int i = 0; i < nbytes; i++) sb_q.push_back({mem[i], 1'b1, i == NB - 1});
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < NB; i++) mem[i] = 8'($urandom);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_res_n"},  oled_res_n, 0);
        chk({tag, "_xmit"},   spi_transmitt, 0);
        chk({tag, "_data"},   spi_data, 0);
        chk({tag, "_dcs"},    spi_deactivate_cs, 0);
        chk({tag, "_dc"},     oled_dc, 0);
        chk({tag, "_busy"},   busy, 1);
        chk({tag, "_init"},   init_done, 0);
        chk({tag, "_fdone"},  frame_done, 0);
        chk({tag, "_fbaddr"}, fb_addr, 0);
    endtask

    task automatic release_and_time();
        int n;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while (!oled_res_n && n < 5000);
        chk("res_low_cycles", n, RST_CYC);
        n = 0;
        do begin
            @(posedge clk_in); #1;
            n++;
        end while (!spi_transmitt && n < 5000);
        chk("powerup_to_first_req", n, PWR_CYC + 1);
    endtask

    task automatic wait_init(input int bound);
        for (int n = 0; ; n++) begin
            @(negedge clk_in);
            if (init_done) break;
            if (n >= bound) begin fail_now("timeout_init_done"); break; end
        end
    endtask

    task automatic wait_fdone(input int bound);
        for (int n = 0; ; n++) begin
            @(negedge clk_in);
            if (frame_done) break;
            if (n >= bound) begin fail_now("timeout_frame_done"); break; end
        end
    endtask

    initial begin
        int fd0, tx0;
        for (int i = 0; i < NB; i++) mem[i] = 8'(i);

        // Reset values and init sequence
        #12;
        check_reset_vals("rst0");
        push_init();
        release_and_time();
        wait_init(5000);
        repeat (3) @(negedge clk_in);
        chk("t1_busy", busy, 0);
        chk("t1_init_done", init_done, 1);
        chk("t1_queue_left", sb_q.size(), 0);

        // Single frame, fb_data = addr[7:0]
        fd0 = fd_cnt;
        push_frame(NB);
        @(negedge clk_in) frame_req = 1'b1;
        @(negedge clk_in) frame_req = 1'b0;
        wait_fdone(20000);
        repeat (5) @(negedge clk_in);
        chk("t2_fdone_pulses", fd_cnt - fd0, 1);
        chk("t2_busy", busy, 0);
        chk("t2_queue_left", sb_q.size(), 0);

        // Back-to-back frames with frame_req held high, random content
        randomize_mem();
        fd0 = fd_cnt;
        push_frame(NB);
        push_frame(NB);
        @(negedge clk_in) frame_req = 1'b1;
        wait_fdone(20000);
        chk("t3_gap_idle", busy, 0);
        @(negedge clk_in);
        chk("t3_gap_len", busy, 1);
        repeat (3) @(negedge clk_in);
        frame_req = 1'b0;
        wait_fdone(20000);
        repeat (10) @(negedge clk_in);
        chk("t3_fdone_pulses", fd_cnt - fd0, 2);
        chk("t3_busy", busy, 0);
        chk("t3_queue_left", sb_q.size(), 0);

        // Reset during data byte 500
        randomize_mem();
        fd0 = fd_cnt;
        tx0 = data_tx;
        push_frame(501);
        @(negedge clk_in) frame_req = 1'b1;
        @(negedge clk_in) frame_req = 1'b0;
        for (int n = 0; ; n++) begin
            @(negedge clk_in);
            if (data_tx - tx0 >= 501) break;
            if (n >= 20000) begin fail_now("timeout_byte500"); break; end
        end
        @(posedge clk_in); #3;
        reset_n_in = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        chk("t5_queue_left", sb_q.size(), 0);
        chk("t5_no_fdone", fd_cnt - fd0, 0);
        sb_q.delete();

        // Request during init, long SPI stalls on init bytes
        frame_req = 1'b1;
        spi_low   = 20;
        repeat (3) @(negedge clk_in);
        push_init();
        push_frame(NB);
        fd0 = fd_cnt;
        release_and_time();
        wait_init(5000);
        spi_low = 8;
        repeat (3) @(negedge clk_in);
        frame_req = 1'b0;
        wait_fdone(20000);
        repeat (10) @(negedge clk_in);
        chk("t4_fdone_pulses", fd_cnt - fd0, 1);
        chk("t4_busy", busy, 0);
        chk("t4_queue_left", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
